int_to_half_conv: RTL and testbench

//  Self-contained int-to-half-float converter with its own 256x8 data memory.
//  - After reset release it reads a 16-bit sign-magnitude integer from memory.
//  - It writes the IEEE-754 binary16 equivalent back to memory, then raises done.
//  - The bench preloads operands and reads results through the memory array hierarchically.

---
 rtl/int_to_half_conv.sv | 175 +++++++++++++++++
 tb/tb_int_to_half_conv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_half_conv.sv
// Integer to IEEE-754 binary16 converter with private 256x8 data memory (instance data_mem1).
// Optional `define INT2HALF_SIGNED_EN treats the operand as two's complement instead of sign-magnitude.

module int_to_half_mem #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] my_memory [0:MEM_DEPTH-1];

    // No reset: contents survive reset so operands can be preloaded while held in reset.
    always @(posedge clk) begin
        if (we) my_memory[addr] <= wdata;
    end

    assign rdata = my_memory[addr];
endmodule

// state | meaning
// IDLE  | waiting one clock after reset release
// RD_HI | latch operand byte [15:8]
// RD_LO | combine with byte [7:0], derive sign and magnitude
// NORM  | shift magnitude left until leading one reaches the top bit
// ROUND | round-to-nearest-even, assemble result word
// WR_HI | write result byte [15:8]
// WR_LO | write result byte [7:0]
// DONE  | hold done until reset
module int_to_half_conv #(
    parameter int ADDR_IN_HI  = 128,
    parameter int ADDR_IN_LO  = 129,
    parameter int ADDR_OUT_HI = 131,
    parameter int ADDR_OUT_LO = 132,
    parameter int MEM_DEPTH   = 256
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
`ifdef INT2HALF_SIGNED_EN
    localparam int MW = 16;
`else
    localparam int MW = 15;
`endif
    localparam logic [4:0] EXP_TOP = 5'(14 + MW);

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, NORM, ROUND, WR_HI, WR_LO, DONE} state_t;

    state_t          state;
    logic [7:0]      in_hi;
    logic            sgn;
    logic [MW-1:0]   norm;
    logic [4:0]      exp_q;
    logic [15:0]     result;

    logic [7:0]      mem_addr;
    logic            mem_we;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    logic [15:0]     operand;
    logic [MW-1:0]   mag_in;
    logic [9:0]      mant_raw;
    logic            guard;
    logic            sticky;
    logic            inc;
    logic [10:0]     mant_sum;
    logic [9:0]      mant_r;
    logic [4:0]      exp_r;

    int_to_half_mem #(.MEM_DEPTH(MEM_DEPTH)) data_mem1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        mem_addr  = 8'(ADDR_IN_HI);
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (state)
            RD_LO: mem_addr = 8'(ADDR_IN_LO);
            WR_HI: begin
                mem_addr  = 8'(ADDR_OUT_HI);
                mem_we    = 1'b1;
                mem_wdata = result[15:8];
            end
            WR_LO: begin
                mem_addr  = 8'(ADDR_OUT_LO);
                mem_we    = 1'b1;
                mem_wdata = result[7:0];
            end
            default: ;
        endcase
    end

    assign operand = {in_hi, mem_rdata};
`ifdef INT2HALF_SIGNED_EN
    assign mag_in = operand[15] ? -operand : operand;
`else
    assign mag_in = operand[14:0];
`endif

    // Leading one sits at norm[MW-1]; bits below it feed mantissa, guard and sticky.
    // Small magnitudes shift in zeros, so exact results fall out without a special case.
    always_comb begin
        mant_raw = norm[MW-2 -: 10];
        guard    = norm[MW-12];
        sticky   = |norm[MW-13:0];
        inc      = guard && (mant_raw[0] || sticky);
        mant_sum = {1'b0, mant_raw} + {10'd0, inc};
        if (mant_sum[10]) begin
            mant_r = 10'd0;
            exp_r  = exp_q + 5'd1;
        end else begin
            mant_r = mant_sum[9:0];
            exp_r  = exp_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            in_hi  <= 8'h00;
            sgn    <= 1'b0;
            norm   <= '0;
            exp_q  <= 5'd0;
            result <= 16'h0000;
        end else begin
            case (state)
                IDLE:  state <= RD_HI;
                RD_HI: begin
                    in_hi <= mem_rdata;
                    state <= RD_LO;
                end
                RD_LO: begin
                    sgn  <= operand[15];
                    norm <= mag_in;
                    if (mag_in == '0) begin
                        exp_q <= 5'd0;
                        state <= ROUND;
                    end else begin
                        exp_q <= EXP_TOP;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (norm[MW-1]) begin
                        state <= ROUND;
                    end else begin
                        norm  <= norm << 1;
                        exp_q <= exp_q - 5'd1;
                    end
                end
                ROUND: begin
                    result <= {sgn, exp_r, mant_r};
                    state  <= WR_HI;
                end
                WR_HI: state <= WR_LO;
                WR_LO: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:  done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_half_conv.sv
// Scoreboard bench for int_to_half_conv: directed spec vectors plus random operands
// checked against an arithmetic round-to-nearest-even model.

module tb_int_to_half_conv;
    logic clk;
    logic reset;
    logic done;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic done_q = 1'b0;

    int_to_half_conv dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_half(input logic [15:0] v);
        int mag, p, q, shift, rem, half;
        logic s;
        s = v[15];
`ifdef INT2HALF_SIGNED_EN
        mag = s ? 65536 - int'(v) : int'(v);
`else
        mag = int'(v[14:0]);
`endif
        if (mag == 0) return {s, 15'd0};
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 10) begin
            q = mag << (10 - p);
        end else begin
            shift = p - 10;
            q     = mag >> shift;
            rem   = mag - (q << shift);
            half  = 1 << (shift - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                p++;
            end
        end
        return {s, 5'(15 + p), 10'(q - 1024)};
    endfunction

    // Monitor: every rising done pops one expectation and checks the result bytes.
    always @(negedge clk) begin
        logic [15:0] want, got;
        if (done && !done_q) begin
            got = {dut.data_mem1.my_memory[131], dut.data_mem1.my_memory[132]};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got=%h with no expectation queued", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL result: got=%h want=%h", got, want);
                end
            end
            total++;
            if (dut.data_mem1.my_memory[130] !== 8'h5A || dut.data_mem1.my_memory[133] !== 8'hA5) begin
                bad++;
                $display("FAIL guard_bytes: got=%h,%h want=5a,a5",
                         dut.data_mem1.my_memory[130], dut.data_mem1.my_memory[133]);
            end
        end
        done_q = done;
    end

    task automatic hold_reset_and_load(input logic [15:0] v);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_in_reset: got=%b want=0", done);
        end
        dut.data_mem1.my_memory[128] <= v[15:8];
        dut.data_mem1.my_memory[129] <= v[7:0];
        dut.data_mem1.my_memory[130] <= 8'h5A;
        dut.data_mem1.my_memory[131] <= 8'hEE;
        dut.data_mem1.my_memory[132] <= 8'hEE;
        dut.data_mem1.my_memory[133] <= 8'hA5;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] v, input logic [15:0] want);
        int cycles;
        hold_reset_and_load(v);
        exp_q.push_back(want);
        reset  = 1'b1;
        cycles = 0;
        while (!done && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        total++;
        if (!done || cycles > 24) begin
            bad++;
            $display("FAIL latency: operand=%h done=%b cycles=%0d want<=24", v, done, cycles);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: done=%b want=0", done);
        end

        run_op(16'h0001, 16'h3C00);
        run_op(16'd3,     16'h4200);
        run_op(16'd12,    16'h4A00);
        run_op(16'd48,    16'h5200);
        run_op(16'd8191,  16'h7000);
        run_op(16'd32767, 16'h7800);
        run_op(16'd30767, 16'h7783);
        run_op(16'd2049,  16'h6800);
        run_op(16'd2051,  16'h6802);
        run_op(16'h0000,  16'h0000);
`ifdef INT2HALF_SIGNED_EN
        run_op(16'h8000,  16'hF800);
        run_op(16'hFFFF,  16'hBC00);
`else
        run_op(16'h8001,  16'hBC00);
`endif

        // Abort during normalisation, then a fresh run must still convert.
        hold_reset_and_load(16'h0001);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL abort_done: got=%b want=0", done);
        end
        total++;
        if ({dut.data_mem1.my_memory[131], dut.data_mem1.my_memory[132]} !== 16'hEEEE) begin
            bad++;
            $display("FAIL abort_no_write: got=%h want=eeee",
                     {dut.data_mem1.my_memory[131], dut.data_mem1.my_memory[132]});
        end
        run_op(16'h0001, 16'h3C00);

        // Reset pulled while done is high must drop it at once.
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_drop: got=%b want=0", done);
        end

        for (int i = 0; i < 24; i++) begin
            v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) v[15] = 1'b1;
            run_op(v, ref_half(v));
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got=%0d pending want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
